// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
//   - bus widths (address, word, size field, response code)
//   - response codes and size encodings used on the peripheral bus
//   - master index constants and the arbiter FSM state encoding
//   - latched request record carried from accept to issue
package mem_bus_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  // Response codes resolved by the peripherals; the arbiter only forwards them.
  localparam logic [MEM_CODE_W-1:0] MEM_OK         = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_ERR_DECODE = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_ERR_ALIGN  = 2'd2;

  // Access size encodings.
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd2;

  // Master indices.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
    logic                   owner;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-input request arbiter, purely combinational.
//   valid0, valid1 : request present from m0 / m1
//   last_grant     : master granted at the previous accept (round-robin history)
//   winner         : index of the master that wins this cycle (M0 when none valid)
//   any_valid      : at least one request present
// ARB_MODE = 0 alternates between the masters when both request;
// ARB_MODE = 1 always prefers m0, so m1 can starve while m0 keeps requesting.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic winner,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    winner    = M0;
    if (ARB_MODE == 1) begin
      if (!valid0 && valid1) winner = M1;
    end else begin
      if (valid0 && valid1) winner = ~last_grant;
      else if (valid1)      winner = M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one peripheral memory bus between m0 (instruction fetch) and
// m1 (data load/store). One transaction in flight at a time:
//   accept at edge T -> request on the bus during T+1 -> response pulse in T+2.
// Ports:
//   clk, aresetn                 : clock, asynchronous active-low reset
//   i_mX_req_* / o_mX_req_ready  : per-master valid/ready request channel
//   o_mX_res_*                   : per-master one-cycle response pulse + data/code
//   o_bus_req_*                  : request driven onto the peripheral bus
//   i_bus_res_*                  : combinational read data / code from the bus
// Outside the ISSUE cycle the bus is parked: read of PARK_ADDR, no write.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                ARB_MODE  = 0,
  parameter logic [ADDR_W-1:0] PARK_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   aresetn,

  input  logic                   i_m0_req_valid,
  output logic                   o_m0_req_ready,
  input  logic [ADDR_W-1:0]      i_m0_req_addr,
  input  logic [WORD_W-1:0]      i_m0_req_wr_data,
  input  logic                   i_m0_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_m0_req_count,
  output logic                   o_m0_res_valid,
  output logic [WORD_W-1:0]      o_m0_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_m0_res_code,

  input  logic                   i_m1_req_valid,
  output logic                   o_m1_req_ready,
  input  logic [ADDR_W-1:0]      i_m1_req_addr,
  input  logic [WORD_W-1:0]      i_m1_req_wr_data,
  input  logic                   i_m1_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_m1_req_count,
  output logic                   o_m1_res_valid,
  output logic [WORD_W-1:0]      o_m1_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_m1_res_code,

  output logic [ADDR_W-1:0]      o_bus_req_addr,
  output logic [WORD_W-1:0]      o_bus_req_wr_data,
  output logic                   o_bus_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_bus_req_count,
  input  logic [WORD_W-1:0]      i_bus_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_bus_res_code
);

  arb_state_e            state, state_next;
  logic                  last_grant;
  mem_req_t              req;
  logic                  winner;
  logic                  any_valid;
  logic                  offer;
  logic                  accept;
  logic [WORD_W-1:0]     m0_rd_data, m1_rd_data;
  logic [MEM_CODE_W-1:0] m0_code, m1_code;

  rr_arbiter2 #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .valid0     (i_m0_req_valid),
    .valid1     (i_m1_req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Ready is offered in IDLE and RESP (back-to-back accepts). Qualifying with
  // aresetn keeps every output low while reset is held, even if a master is
  // still asserting valid.
  assign offer  = aresetn && ((state == IDLE) || (state == RESP));
  assign accept = offer && any_valid;

  assign o_m0_req_ready = offer && i_m0_req_valid && (winner == M0);
  assign o_m1_req_ready = offer && i_m1_req_valid && (winner == M1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = accept ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= M1;
    end else begin
      state <= state_next;
      if (accept) last_grant <= winner;
    end
  end

  // Request latch: only the winner's payload is captured, so the other
  // master's (possibly undriven) payload never reaches the bus.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      req <= '0;
    end else if (accept) begin
      if (winner == M1) begin
        req.addr    <= i_m1_req_addr;
        req.wr_data <= i_m1_req_wr_data;
        req.wr_en   <= i_m1_req_wr_en;
        req.count   <= i_m1_req_count;
        req.owner   <= M1;
      end else begin
        req.addr    <= i_m0_req_addr;
        req.wr_data <= i_m0_req_wr_data;
        req.wr_en   <= i_m0_req_wr_en;
        req.count   <= i_m0_req_count;
        req.owner   <= M0;
      end
    end
  end

  // Response capture at the edge closing the ISSUE cycle. Registers hold their
  // value afterwards; they are only meaningful while res_valid is high.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m0_rd_data <= '0;
      m0_code    <= '0;
      m1_rd_data <= '0;
      m1_code    <= '0;
    end else if (state == ISSUE) begin
      if (req.owner == M1) begin
        m1_rd_data <= i_bus_res_rd_data;
        m1_code    <= i_bus_res_code;
      end else begin
        m0_rd_data <= i_bus_res_rd_data;
        m0_code    <= i_bus_res_code;
      end
    end
  end

  assign o_m0_res_valid   = (state == RESP) && (req.owner == M0);
  assign o_m1_res_valid   = (state == RESP) && (req.owner == M1);
  assign o_m0_res_rd_data = m0_rd_data;
  assign o_m0_res_code    = m0_code;
  assign o_m1_res_rd_data = m1_rd_data;
  assign o_m1_res_code    = m1_code;

  // The latched request appears on the bus only during ISSUE; a write can
  // therefore never be presented in any other cycle.
  always_comb begin
    o_bus_req_addr    = PARK_ADDR;
    o_bus_req_wr_data = '0;
    o_bus_req_wr_en   = 1'b0;
    o_bus_req_count   = '0;
    if (state == ISSUE) begin
      o_bus_req_addr    = req.addr;
      o_bus_req_wr_data = req.wr_data;
      o_bus_req_wr_en   = req.wr_en;
      o_bus_req_count   = req.count;
    end
  end

endmodule
